// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width and the branch funct3 encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic equal;
    logic lessthan;
    logic taken;
  } branch_result_t;

endpackage

// File: rtl/magnitude_compare.sv
// Equality and signed/unsigned less-than of two operands via a (WIDTH+1)-bit subtract.
module magnitude_compare #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             eq,
  output logic             lt
);

  logic [WIDTH:0] ext_a;
  logic [WIDTH:0] ext_b;

  // Extending with the sign bit (signed) or zero (unsigned) lets one subtractor serve
  // both modes; the difference cannot overflow at WIDTH+1 bits, so its MSB is the borrow.
  assign ext_a = {is_signed & a[WIDTH-1], a};
  assign ext_b = {is_signed & b[WIDTH-1], b};

  assign eq = (a == b);
  assign lt = 1'((ext_a - ext_b) >> WIDTH);

endmodule

// File: rtl/branch_comparator_unit.sv
// RV32I branch comparator: combinational eq/lt/taken plus a registered copy for the pipeline.
module branch_comparator_unit
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_branch_unsigned,
  input  logic [WIDTH-1:0] I_data1,
  input  logic [WIDTH-1:0] I_data2,
  input  logic [2:0]       I_funct3,
  input  logic             I_branch,
  output logic             O_branch_equal,
  output logic             O_branch_lessthan,
  output logic             O_branch_taken,
  output logic             O_branch_equal_q,
  output logic             O_branch_lessthan_q,
  output logic             O_branch_taken_q
);

  logic           eq;
  logic           lt;
  logic           taken;
  branch_result_t result_q;

  magnitude_compare #(.WIDTH(WIDTH)) u_magnitude_compare (
    .a         (I_data1),
    .b         (I_data2),
    .is_signed (~I_branch_unsigned),
    .eq        (eq),
    .lt        (lt)
  );

  // The comparison mode comes from the control unit, not from funct3, so BLTU/BGEU
  // simply reuse whatever lt the selected mode produced.
  always_comb begin
    // NOTE: assign a default before the case so every path drives taken and no latch is inferred.
    taken = 1'b0;
    if (I_branch) begin
      case (I_funct3)
        F3_BEQ:           taken = eq;
        F3_BNE:           taken = ~eq;
        F3_BLT, F3_BLTU:  taken = lt;
        F3_BGE, F3_BGEU:  taken = ~lt;
        default:          taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      result_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all three bits update together.
      result_q <= '{equal: eq, lessthan: lt, taken: taken};
    end
  end

  assign O_branch_equal      = eq;
  assign O_branch_lessthan   = lt;
  assign O_branch_taken      = taken;
  assign O_branch_equal_q    = result_q.equal;
  assign O_branch_lessthan_q = result_q.lessthan;
  assign O_branch_taken_q    = result_q.taken;

endmodule

// File: tb/tb_branch_comparator_unit.sv
// Self-checking bench for branch_comparator_unit: directed plan vectors plus randomized traffic vs. a model.
module tb_branch_comparator_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_unsigned;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  funct3;
  logic        branch;
  logic        eq, lt, tk;
  logic        eq_q, lt_q, tk_q;

  int n_checks = 0;
  int n_fail   = 0;

  branch_comparator_unit #(.WIDTH(32)) dut (
    .I_clk               (clk),
    .I_rst_n             (rst_n),
    .I_branch_unsigned   (branch_unsigned),
    .I_data1             (data1),
    .I_data2             (data2),
    .I_funct3            (funct3),
    .I_branch            (branch),
    .O_branch_equal      (eq),
    .O_branch_lessthan   (lt),
    .O_branch_taken      (tk),
    .O_branch_equal_q    (eq_q),
    .O_branch_lessthan_q (lt_q),
    .O_branch_taken_q    (tk_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: branch semantics straight from the ISA rules using native comparisons.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input logic uns, input logic [2:0] f3, input logic br);
    logic m_eq, m_lt, m_tk;
    m_eq = (a == b);
    m_lt = uns ? (a < b) : ($signed(a) < $signed(b));
    m_tk = 1'b0;
    if (br) begin
      case (f3)
        3'd0:       m_tk = m_eq;
        3'd1:       m_tk = !m_eq;
        3'd4, 3'd6: m_tk = m_lt;
        3'd5, 3'd7: m_tk = !m_lt;
        default:    m_tk = 1'b0;
      endcase
    end
    return {m_eq, m_lt, m_tk};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic uns,
                       input logic [2:0] f3, input logic br);
    data1 = a; data2 = b; branch_unsigned = uns; funct3 = f3; branch = br;
  endtask

  int vec_idx = 0;

  // Directed vector: driven at the falling edge, compared 1 time unit later.
  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic uns,
                     input logic [2:0] f3, input logic br,
                     input logic e_eq, input logic e_lt, input logic e_tk);
    @(negedge clk);
    drive(a, b, uns, f3, br);
    #1;
    check($sformatf("dir%0d_eq", vec_idx), 32'(eq), 32'(e_eq));
    check($sformatf("dir%0d_lt", vec_idx), 32'(lt), 32'(e_lt));
    check($sformatf("dir%0d_taken", vec_idx), 32'(tk), 32'(e_tk));
    vec_idx++;
  endtask

  initial begin
    logic [2:0]  exp;
    logic [31:0] a, b;
    logic        uns, br;
    logic [2:0]  f3;

    rst_n = 1'b0;
    drive(32'd1, 32'd1, 1'b0, 3'b000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_eq_q", 32'(eq_q), 32'd0);
    check("reset_lt_q", 32'(lt_q), 32'd0);
    check("reset_taken_q", 32'(tk_q), 32'd0);
    check("reset_comb_eq", 32'(eq), 32'd1);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_eq_q", 32'(eq_q), 32'd1);
    check("release_taken_q", 32'(tk_q), 32'd1);
    check("release_lt_q", 32'(lt_q), 32'd0);

    // Signed mode, small operands (BEQ so taken mirrors eq)
    dir(32'd1, 32'd2, 0, 3'b000, 1, 0, 1, 0);
    dir(32'd2, 32'd1, 0, 3'b000, 1, 0, 0, 0);
    dir(32'd1, 32'd1, 0, 3'b000, 1, 1, 0, 1);
    dir(32'd1, 32'd0, 0, 3'b000, 1, 0, 0, 0);
    dir(32'd0, 32'd0, 0, 3'b000, 1, 1, 0, 1);
    // Signed mode, negative operands
    dir(32'h0000_0000, 32'hFFFF_FFFF, 0, 3'b000, 1, 0, 0, 0);
    dir(32'hFFFF_FFFF, 32'h0000_0000, 0, 3'b000, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'b000, 1, 1, 0, 1);
    dir(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 3'b000, 1, 0, 0, 0);
    dir(32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 3'b000, 1, 0, 1, 0);
    dir(32'hFFFF_FFFE, 32'hFFFF_FFFE, 0, 3'b000, 1, 1, 0, 1);
    // Unsigned mode and the sign-boundary pair in both modes
    dir(32'h0000_0000, 32'hFFFF_FFFF, 1, 3'b000, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0000_0000, 1, 3'b000, 1, 0, 0, 0);
    dir(32'h8000_0000, 32'h7FFF_FFFF, 1, 3'b000, 1, 0, 0, 0);
    dir(32'h8000_0000, 32'h7FFF_FFFF, 0, 3'b000, 1, 0, 1, 0);
    // Decode with (-1, 0) signed: eq=0, lt=1
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b000, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b001, 1, 0, 1, 1);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b100, 1, 0, 1, 1);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b101, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b010, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b011, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b110, 1, 0, 1, 1);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b111, 1, 0, 1, 0);
    dir(32'hFFFF_FFFF, 32'h0, 0, 3'b001, 0, 0, 1, 0);

    // Randomized traffic; a throwaway value is applied mid-cycle before the real one
    // so the registers must hold only what is present at the rising edge.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        2:       b = {~a[31], $urandom_range(0, 15) == 0 ? a[30:0] : 31'($urandom)};
        default: b = $urandom;
      endcase
      uns = 1'($urandom);
      f3  = 3'($urandom);
      br  = ($urandom_range(0, 7) != 0);
      drive(a, b, uns, f3, br);
      exp = model(a, b, uns, f3, br);
      #1;
      check("rand_eq", 32'(eq), 32'(exp[2]));
      check("rand_lt", 32'(lt), 32'(exp[1]));
      check("rand_taken", 32'(tk), 32'(exp[0]));
      @(posedge clk);
      #1;
      check("rand_eq_q", 32'(eq_q), 32'(exp[2]));
      check("rand_lt_q", 32'(lt_q), 32'(exp[1]));
      check("rand_taken_q", 32'(tk_q), 32'(exp[0]));
      #1;
      drive(~a, a, ~uns, ~f3, ~br);
    end

    // Asynchronous reset asserted mid-cycle with (1,1) registered
    @(negedge clk);
    drive(32'd1, 32'd1, 1'b0, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    check("pre_async_eq_q", 32'(eq_q), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_eq_q", 32'(eq_q), 32'd0);
    check("async_lt_q", 32'(lt_q), 32'd0);
    check("async_taken_q", 32'(tk_q), 32'd0);
    check("async_comb_eq", 32'(eq), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_taken_q", 32'(tk_q), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_comparator_unit.md
# branch_comparator_unit

Branch condition comparator for the RV32I execute stage. It compares the two register-source operands and reports equality and less-than, signed or unsigned as selected. It also decodes the branch `funct3` field into a single branch-taken flag for the PC-select logic. Comparison results are combinational; a registered copy is provided for the pipeline/debug path.

## Interface
Parameters:
- `WIDTH`, default 32, operand width in bits.

Ports:
- `I_clk`  in  1  single clock; drives only the registered result copy.
- `I_rst_n`  in  1  reset, asynchronous, active-low; clears registered outputs.
- `I_branch_unsigned`  in  1  selects the comparison mode: 1 = unsigned, 0 = signed two's-complement.
- `I_data1`  in  WIDTH  operand rs1.
- `I_data2`  in  WIDTH  operand rs2.
- `I_funct3`  in  3  branch type: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- `I_branch`  in  1  current instruction is a conditional branch.
- `O_branch_equal`  out  1  combinational: `I_data1 == I_data2`.
- `O_branch_lessthan`  out  1  combinational: `I_data1 < I_data2` in the selected mode.
- `O_branch_taken`  out  1  combinational branch decision.
- `O_branch_equal_q`  out  1  registered `O_branch_equal`.
- `O_branch_lessthan_q`  out  1  registered `O_branch_lessthan`.
- `O_branch_taken_q`  out  1  registered `O_branch_taken`.

## Operation
- **Equality:** bitwise compare of the operands. It is independent of `I_branch_unsigned`.
- **Less-than:** computed as a (WIDTH+1)-bit subtraction `{x1,I_data1} - {x2,I_data2}`.
  - `x` is the operand MSB in signed mode and 0 in unsigned mode.
  - `O_branch_lessthan` is bit WIDTH of the result.
  - No overflow is possible at WIDTH+1 bits.
- **Equal operands:** `O_branch_lessthan` = 0 whenever `O_branch_equal` = 1.
- **Branch decision** (`O_branch_taken`):
  - BEQ → eq; BNE → !eq; BLT/BLTU → lt; BGE/BGEU → !lt.
- **Mode ownership:** `I_branch_unsigned` is supplied externally by the control unit and is not derived from `funct3`. `O_branch_taken` uses `O_branch_lessthan` as computed under `I_branch_unsigned`.
- **Forcing taken low:** `O_branch_taken` = 0 when `I_branch` = 0, or when `funct3` is 010 or 011 (reserved).
- **No internal state** other than the three result registers.

## Timing
- **Combinational outputs:** settle within one combinational path after any input change. They must not depend on `I_clk` and are valid even when the clock is idle.
- **Registered outputs:**
  - Capture the combinational values on the rising edge of `I_clk`; latency is 1 cycle.
  - `I_rst_n` low clears all three `_q` outputs to 0 immediately, asynchronously.
  - Release of reset takes effect at the next rising edge.
  - Reset has no effect on the combinational outputs.
- **Mid-cycle changes:** if operands change mid-cycle, only the value present at the rising edge is registered.

## Structure
- **Shared package `riscv_pkg`:** holds the `funct3` branch constants (`F3_BEQ` … `F3_BGEU`) and `XLEN` = 32.
- **Sub-module `magnitude_compare`:** a natural single sub-module.
  - Parameterised by WIDTH.
  - Inputs: two operands and a signed flag.
  - Outputs: `eq` and `lt` via the extended subtract.
- **Top level:** contains the `funct3` decode and the output registers.

## Test plan
1. **Signed mode** (`I_branch_unsigned`=0), expected eq/lt for (data1, data2):
   - (1,2) → 0/1; (2,1) → 0/0; (1,1) → 1/0; (1,0) → 0/0; (0,0) → 1/0.
2. **Signed mode, negative operands:**
   - (0,-1) → 0/0; (-1,0) → 0/1; (-1,-1) → 1/0; (-1,-2) → 0/0; (-2,-1) → 0/1; (-2,-2) → 1/0.
3. **Unsigned mode:**
   - (0, 0xFFFFFFFF) → lt=1; (0xFFFFFFFF, 0) → lt=0.
   - (0x80000000, 0x7FFFFFFF) → lt=0 unsigned, lt=1 when switched to signed.
4. **Decode**, with `I_branch`=1 and data (-1,0) signed:
   - BEQ → 0; BNE → 1; BLT → 1; BGE → 0; funct3=010 → 0.
   - `I_branch`=0 with BNE → 0.
5. **Registers:**
   - Hold `I_rst_n`=0 with (1,1) applied → all `_q` = 0.
   - Release reset; after one rising edge → `O_branch_equal_q`=1.
   - Assert `I_rst_n` low mid-cycle → all `_q` = 0 without waiting for a clock edge.
